exts_arbiter: RTL and testbench
===============================

Name: exts_arbiter

Overview:
- Shares one sign-extension datapath (byte/halfword extension selected by Pu_types::Alu_op) between NREQ requesters, e.g. load-format path and ALU issue.
- Round-robin arbitration, valid/ready handshakes on each requester and on the result side.
- One registered output stage; results tagged with the winning requester index.
- Sits between the issue/load units and writeback.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, $clog2(NREQ) (min 1), width of the result tag.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-low reset; all state is cleared on a rising clk edge while reset==0.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant/accept, one-hot or zero.
- req_op  input  NREQ x Alu_op  per-requester operation.
- req_win  input  NREQ x 32  per-requester input word (Pu_types::Word).
- res_valid  output  1  result register holds valid data.
- res_ready  input  1  consumer accepts the result.
- res_data  output  32  extended word.
- res_tag  output  IDW  index of the requester that produced res_data.
- grant_count  output  NREQ x 16  per-requester grant counters; present only with EXTS_ARB_STATS_EN.

Behaviour:
- Extension function:
  - Alu_esb: {24{win[7]}, win[7:0]}.
  - Alu_esh: {16{win[15]}, win[15:0]}.
  - Any other op: win passes through unchanged.
- can_accept = !res_valid || res_ready (combinational).
- Arbitration, combinational within the cycle:
  - Search starts at rr_ptr, increments modulo NREQ, and picks the first i with req_valid[i].
  - req_ready[i]=1 only for that i, and only when can_accept.
  - req_ready must not depend on res_data.
- Transfer on requester i when req_valid[i] && req_ready[i]. At the next edge:
  - res_data <= ext(req_op[i], req_win[i]); res_tag <= i; res_valid <= 1.
  - rr_ptr <= (i+1) mod NREQ.
- If res_ready && res_valid and there is no new transfer: res_valid <= 0. res_data and res_tag hold their values.
- Simultaneous drain and accept: the register is overwritten and res_valid stays 1. Throughput is 1 result/cycle.
- Latency: accept at edge N gives res_valid at cycle N+1.
- Backpressure: while res_valid && !res_ready, all req_ready are 0 and res_data, res_tag, res_valid are held stable.
- rr_ptr changes only on a transfer. An idle cycle does not move it.
- No requests: req_ready=0 and the register state is unchanged apart from a drain.
- Wrap-around: a grant to index NREQ-1 sets rr_ptr to 0.
- Reset values: res_valid=0, res_data=0, res_tag=0, rr_ptr=0, grant_count=0. req_ready=0 during reset.
- Reset while res_valid=1 discards the pending result. No handshake completes in a reset cycle.
- Requesters may drop req_valid without being granted; the block holds no request state.

Optional Feature:
- Macro: EXTS_ARB_STATS_EN.
- Defined:
  - grant_count[i] increments by 1 on each transfer from requester i and saturates at 16'hFFFF.
  - Cleared by reset only.
- Undefined:
  - grant_count port and the counters are absent.
  - All other behaviour is identical.

Test Plan:
- Single requester: NREQ=2; req0 valid with Alu_esb, win=32'h0000_0080, res_ready=1. Required: req_ready=2'b01; next cycle res_valid=1, res_data=32'hFFFF_FF80, res_tag=0.
- Halfword and pass-through: esh on 32'h1234_7FFF gives 32'h0000_7FFF. A non-extension op on 32'hDEAD_BEEF gives 32'hDEAD_BEEF.
- Fairness: both requesters valid continuously, res_ready=1. Required: grants alternate 0,1,0,1, res_tag alternates the same way, one result per cycle.
- Backpressure: a result is held with res_ready=0 for 3 cycles while both requesters are valid. Required: req_ready=0 and res_data/res_tag stable throughout. When res_ready rises, the accept and drain happen in the same cycle and res_valid stays 1.
- Reset mid-operation: reset=0 while res_valid=1 and rr_ptr=1. Required: after the edge, res_valid=0 and the first grant after reset goes to req0 when both are valid.
- Stats (EXTS_ARB_STATS_EN): 5 grants to req1. Required: grant_count[1]=5 and grant_count[0]=0. A counter preset near saturation stops at 16'hFFFF.

Source files
------------

// File: rtl/exts_arbiter.sv
// exts_arbiter: round-robin arbiter in front of a shared byte/halfword
// sign-extension unit, with one registered result stage tagged by winner.
// Optional feature macro: EXTS_ARB_STATS_EN (per-requester grant counters).

package Pu_types;
    localparam int unsigned OPW = 4;

    typedef enum logic [OPW-1:0] {
        Alu_add = 4'd0,
        Alu_sub = 4'd1,
        Alu_and = 4'd2,
        Alu_or  = 4'd3,
        Alu_xor = 4'd4,
        Alu_esb = 4'd5,
        Alu_esh = 4'd6,
        Alu_sll = 4'd7
    } Alu_op;

    typedef logic [31:0] Word;
endpackage

module exts_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ*Pu_types::OPW-1:0]  req_op,
    input  logic [NREQ*32-1:0]             req_win,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [31:0]                    res_data,
    output logic [IDW-1:0]                 res_tag
`ifdef EXTS_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]             grant_count
`endif
);

    localparam int unsigned OPW = Pu_types::OPW;

    logic            res_valid_q, res_valid_d;
    logic [31:0]     res_data_q,  res_data_d;
    logic [IDW-1:0]  res_tag_q,   res_tag_d;
    logic [IDW-1:0]  rr_ptr_q,    rr_ptr_d;

    logic            can_accept_c;
    logic            found_c;
    logic            grant_c;
    logic [IDW-1:0]  win_idx_c;

    // Byte/halfword sign extension; everything else passes through.
    function automatic logic [31:0] ext_f(input logic [OPW-1:0] op, input logic [31:0] w);
        logic [31:0] r;
        case (op)
            Pu_types::Alu_esb: r = {{24{w[7]}}, w[7:0]};
            Pu_types::Alu_esh: r = {{16{w[15]}}, w[15:0]};
            default:           r = w;
        endcase
        return r;
    endfunction

    // Round-robin search starting at rr_ptr; grant only when the stage can take it.
    always_comb begin
        int unsigned cand;
        can_accept_c = !res_valid_q || res_ready;
        found_c      = 1'b0;
        win_idx_c    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found_c && req_valid[IDW'(cand)]) begin
                found_c   = 1'b1;
                win_idx_c = IDW'(cand);
            end
        end
        grant_c = found_c && can_accept_c && reset;
    end

    // One-hot ready to the winner only.
    always_comb begin
        req_ready = '0;
        if (grant_c) req_ready[win_idx_c] = 1'b1;
    end

    // Next-state of the result stage and round-robin pointer.
    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_tag_d   = res_tag_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_c) begin
            res_valid_d = 1'b1;
            res_data_d  = ext_f(req_op[32'(win_idx_c)*OPW +: OPW],
                                req_win[32'(win_idx_c)*32 +: 32]);
            res_tag_d   = win_idx_c;
            rr_ptr_d    = (win_idx_c == IDW'(NREQ - 1)) ? '0 : win_idx_c + IDW'(1);
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // Result stage and pointer registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_tag_q   <= res_tag_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_tag   = res_tag_q;

`ifdef EXTS_ARB_STATS_EN
    logic [NREQ-1:0][15:0] cnt_q, cnt_d;

    // Saturating per-requester grant counters.
    always_comb begin
        cnt_d = cnt_q;
        if (grant_c && cnt_q[win_idx_c] != 16'hFFFF)
            cnt_d[win_idx_c] = cnt_q[win_idx_c] + 16'd1;
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_exts_arbiter.sv
// Self-checking bench for exts_arbiter (NREQ=2): directed vectors plus a
// cycle-by-cycle comparison against a behavioural model.
module tb_exts_arbiter;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*4-1:0]   req_op;
    logic [NREQ*32-1:0]  req_win;
    logic                res_valid;
    logic                res_ready;
    logic [31:0]         res_data;
    logic [IDW-1:0]      res_tag;
`ifdef EXTS_ARB_STATS_EN
    logic [NREQ*16-1:0]  grant_count;
`endif

    exts_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_win(req_win),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag)
`ifdef EXTS_ARB_STATS_EN
        , .grant_count(grant_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit          started = 0;
    bit          m_valid;
    logic [31:0] m_data;
    int          m_tag;
    int          m_ptr;
    int          m_cnt[NREQ];

    function automatic logic [31:0] ext_m(input logic [3:0] op, input logic [31:0] w);
        int sx;
        if (op == Pu_types::Alu_esb) begin
            sx = $signed(w[7:0]);
            return sx;
        end
        if (op == Pu_types::Alu_esh) begin
            sx = $signed(w[15:0]);
            return sx;
        end
        return w;
    endfunction

    // Index granted this cycle, or -1.
    function automatic int model_grant();
        int i;
        if (reset !== 1'b1) return -1;
        if (m_valid && !res_ready) return -1;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        if (reset === 1'b0) begin
            started = 1;
            m_valid = 0; m_data = 32'h0; m_tag = 0; m_ptr = 0;
            for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        end else if (started) begin
            g = model_grant();
            if (g >= 0) begin
                m_data  = ext_m(req_op[g*4 +: 4], req_win[g*32 +: 32]);
                m_tag   = g;
                m_valid = 1;
                m_ptr   = (g + 1) % NREQ;
                if (m_cnt[g] < 65535) m_cnt[g]++;
            end else if (res_ready && m_valid) begin
                m_valid = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int g;
        logic [NREQ-1:0] exp_rdy;
        if (started) begin
            g = model_grant();
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("model req_ready", 32'(req_ready), 32'(exp_rdy));
            check("model res_valid", 32'(res_valid), 32'(m_valid));
            check("model res_data",  res_data, m_data);
            check("model res_tag",   32'(res_tag), 32'(m_tag));
`ifdef EXTS_ARB_STATS_EN
            for (int i = 0; i < NREQ; i++)
                check("model grant_count", 32'(grant_count[i*16 +: 16]), 32'(m_cnt[i]));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] op, input logic [31:0] w);
        req_valid[i]     = v;
        req_op[i*4 +: 4] = op;
        req_win[i*32 +: 32] = w;
    endtask

    initial begin
        reset = 1'b0; req_valid = '0; req_op = '0; req_win = '0; res_ready = 1'b1;
        set_req(0, 1'b1, 4'(Pu_types::Alu_add), 32'h1);
        set_req(1, 1'b1, 4'(Pu_types::Alu_add), 32'h2);
        cyc();
        #2 check("ready in reset", 32'(req_ready), 32'h0);
        cyc();
        check("reset res_valid", 32'(res_valid), 32'h0);
        check("reset res_data",  res_data, 32'h0);
        check("reset res_tag",   32'(res_tag), 32'h0);

        // single requester, byte extension
        reset = 1'b1;
        req_valid = '0;
        set_req(0, 1'b1, 4'(Pu_types::Alu_esb), 32'h0000_0080);
        #2 check("esb ready", 32'(req_ready), 32'h1);
        cyc();
        check("esb valid", 32'(res_valid), 32'h1);
        check("esb data",  res_data, 32'hFFFF_FF80);
        check("esb tag",   32'(res_tag), 32'h0);

        // halfword extension on req1
        req_valid = '0;
        set_req(1, 1'b1, 4'(Pu_types::Alu_esh), 32'h1234_7FFF);
        #2 check("esh ready", 32'(req_ready), 32'h2);
        cyc();
        check("esh data", res_data, 32'h0000_7FFF);
        check("esh tag",  32'(res_tag), 32'h1);

        // pass-through, req1 granted from ptr 0 (search wraps past idle req0)
        set_req(1, 1'b1, 4'(Pu_types::Alu_add), 32'hDEAD_BEEF);
        #2 check("pass ready", 32'(req_ready), 32'h2);
        cyc();
        check("pass data", res_data, 32'hDEAD_BEEF);

        // fairness: both valid, grants alternate 0,1,0,1
        set_req(0, 1'b1, 4'(Pu_types::Alu_esb), 32'h0000_007F);
        set_req(1, 1'b1, 4'(Pu_types::Alu_esh), 32'h0000_8000);
        for (int k = 0; k < 4; k++) begin
            #2 check("fair ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            cyc();
            check("fair valid", 32'(res_valid), 32'h1);
            check("fair tag",   32'(res_tag), 32'(k % 2));
            check("fair data",  res_data, (k % 2 == 0) ? 32'h0000_007F : 32'hFFFF_8000);
        end

        // backpressure for 3 cycles
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2 check("bp ready", 32'(req_ready), 32'h0);
            cyc();
            check("bp valid", 32'(res_valid), 32'h1);
            check("bp tag",   32'(res_tag), 32'h1);
            check("bp data",  res_data, 32'hFFFF_8000);
        end
        res_ready = 1'b1;
        #2 check("bp release ready", 32'(req_ready), 32'h1);
        cyc();
        check("bp release valid", 32'(res_valid), 32'h1);
        check("bp release tag",   32'(res_tag), 32'h0);

        // reset while holding a result with rr_ptr=1
        reset = 1'b0;
        #2 check("rst mid ready", 32'(req_ready), 32'h0);
        cyc();
        check("rst mid valid", 32'(res_valid), 32'h0);
        check("rst mid tag",   32'(res_tag), 32'h0);
        reset = 1'b1;
        #2 check("post rst ready", 32'(req_ready), 32'h1);
        cyc();
        check("post rst tag", 32'(res_tag), 32'h0);

        // idle cycle drains but keeps the pointer
        req_valid = '0;
        #2 check("idle ready", 32'(req_ready), 32'h0);
        cyc();
        check("idle valid", 32'(res_valid), 32'h0);
        check("idle data hold", res_data, 32'h0000_007F);
        req_valid = 2'b11;
        #2 check("after idle ready", 32'(req_ready), 32'h2);
        cyc();
        check("after idle tag", 32'(res_tag), 32'h1);

        // mixed traffic checked by the model
        for (int k = 0; k < 60; k++) begin
            req_valid = NREQ'($urandom_range(0, 3));
            res_ready = 1'($urandom_range(0, 1));
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 2))
                    0:       req_op[i*4 +: 4] = 4'(Pu_types::Alu_esb);
                    1:       req_op[i*4 +: 4] = 4'(Pu_types::Alu_esh);
                    default: req_op[i*4 +: 4] = 4'(Pu_types::Alu_xor);
                endcase
                req_win[i*32 +: 32] = $urandom;
            end
            cyc();
        end

`ifdef EXTS_ARB_STATS_EN
        reset = 1'b0; req_valid = '0; res_ready = 1'b1;
        cyc();
        reset = 1'b1;
        req_valid = 2'b10;
        for (int k = 0; k < 5; k++) cyc();
        req_valid = '0;
        check("stats cnt1", 32'(grant_count[31:16]), 32'd5);
        check("stats cnt0", 32'(grant_count[15:0]),  32'd0);
        req_valid = 2'b10;
        for (int k = 0; k < 65540; k++) cyc();
        req_valid = '0;
        check("stats sat", 32'(grant_count[31:16]), 32'h0000_FFFF);
`endif

        cyc();
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
